// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam int ARB_N        = 4;
  localparam int ARB_HOLD_MAX = 8;

  // Index width for an N-wide vector; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(ARB_N)-1:0] idx_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req searching ptr, ptr+1, ... mod N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          found
);

  int k;

  // Walk the rotated order backwards so the earliest hit is written last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    k      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        winner = IW'(k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with ack handshake and HOLD_MAX revoke; registered onehot0 grant.
// Optional onehot0 checker on gnt enabled by RR_GRANT_ARBITER_CHK_EN.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int HOLD_MAX = ARB_HOLD_MAX,
  parameter int IW       = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx,
  output logic          timeout,
  output logic          err_onehot
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ev_grant, ev_timeout;

  logic [N-1:0]  pick_req;
  logic [IW-1:0] pick_ptr, pick_win, win_inc;
  logic          pick_found;

  logic [N-1:0]  gnt_nxt;
  logic [IW-1:0] idx_nxt;

  // gnt_idx doubles as the held winner while in GRANT.
  assign win_inc  = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  // In IDLE gnt is 0 so the mask is a no-op; in GRANT it drops the releasing owner.
  assign pick_req = req & ~gnt;
  assign pick_ptr = (state == GRANT) ? win_inc : ptr;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .winner (pick_win),
    .found  (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    ev_grant   = 1'b0;
    ev_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          ev_grant  = 1'b1;
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_nxt = win_inc;
          if (pick_found) ev_grant  = 1'b1;
          else            state_nxt = IDLE;
        end else if (!req[gnt_idx]) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(HOLD_MAX - 1)) begin
          state_nxt  = IDLE;
          ev_timeout = 1'b1;
          ptr_nxt    = win_inc;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (ev_grant) cnt_nxt = '0;
  end

  always_comb begin
    gnt_nxt = '0;
    idx_nxt = '0;
    if (state_nxt == GRANT) begin
      idx_nxt = ev_grant ? pick_win : gnt_idx;
      gnt_nxt = ev_grant ? (N'(1) << pick_win) : gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
      timeout <= 1'b0;
    end else begin
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      gnt_vld <= (state_nxt == GRANT);
      gnt_idx <= idx_nxt;
      timeout <= ev_timeout;
    end
  end

`ifdef RR_GRANT_ARBITER_CHK_EN
  logic bad_gnt;
  assign bad_gnt = !$onehot0(gnt) || (gnt_vld != (|gnt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_onehot <= 1'b0;
    else     err_onehot <= err_onehot | bad_gnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!bad_gnt) else $error("rr_grant_arbiter: gnt not onehot0 (%b)", gnt);
  end
`else
  assign err_onehot = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed vector table, async reset sequence, random vs. model.
module tb_rr_grant_arbiter;
  localparam int N  = 4;
  localparam int HM = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         ack;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_idx;
  logic         timeout;
  logic         err_onehot;

  int total = 0;
  int bad   = 0;

  rr_grant_arbiter #(.N(N), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .gnt(gnt), .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx), .timeout(timeout), .err_onehot(err_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] gnt;
    logic         to;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [N-1:0] eg, input logic et);
    logic [1:0] ei;
    ei = 2'd0;
    for (int i = 0; i < N; i++) if (eg[i]) ei = 2'(i);
    total++;
    if (gnt !== eg || gnt_vld !== (|eg) || gnt_idx !== ei || timeout !== et || err_onehot !== 1'b0) begin
      bad++;
      $display("FAIL %s: got gnt=%b vld=%b idx=%0d to=%b err=%b, want gnt=%b vld=%b idx=%0d to=%b err=0",
               nm, gnt, gnt_vld, gnt_idx, timeout, err_onehot, eg, |eg, ei, et);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [N-1:0] r, input logic a, input logic [N-1:0] g, input logic t);
    vec_t v;
    v.req = r; v.ack = a; v.gnt = g; v.to = t;
    tbl.push_back(v);
  endtask

  // Reference: owner index (-1 = none), pointer and hold count as plain ints.
  int m_own, m_ptr, m_cnt;
  logic m_to;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic a);
    logic [N-1:0] m;
    m_to = 1'b0;
    if (m_own < 0) begin
      m_own = first_from(r, m_ptr);
      m_cnt = 0;
    end else if (a) begin
      m_ptr = (m_own + 1) % N;
      m = r;
      m[m_own] = 1'b0;
      m_own = first_from(m, m_ptr);
      m_cnt = 0;
    end else if (!r[m_own]) begin
      m_own = -1;
    end else if (m_cnt == HM - 1) begin
      m_to  = 1'b1;
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end else begin
      m_cnt++;
    end
  endtask

  initial begin
    logic [N-1:0] r;
    logic         a;
    logic [N-1:0] eg;

    rst = 1'b1; req = '0; ack = 1'b0;
    #1;
    check("reset_async", '0, 1'b0);
    @(posedge clk); #1;
    check("reset_hold", '0, 1'b0);
    rst = 1'b0;

    // rotation with ack every 2nd cycle
    add(4'hF, 0, 4'b0001, 0); add(4'hF, 0, 4'b0001, 0);
    add(4'hF, 1, 4'b0010, 0); add(4'hF, 0, 4'b0010, 0);
    add(4'hF, 1, 4'b0100, 0); add(4'hF, 0, 4'b0100, 0);
    add(4'hF, 1, 4'b1000, 0); add(4'hF, 0, 4'b1000, 0);
    add(4'hF, 1, 4'b0001, 0); add(4'h0, 0, 4'b0000, 0);
    // hold timeout: 8 grant cycles, pulse with gnt=0, regrant after one idle cycle
    for (int i = 0; i < HM; i++) add(4'b0100, 0, 4'b0100, 0);
    add(4'b0100, 0, 4'b0000, 1); add(4'b0100, 0, 4'b0100, 0);
    add(4'h0, 0, 4'b0000, 0);
    // get ptr=1, then back-to-back idx3 -> idx0 -> idx3
    add(4'b0001, 0, 4'b0001, 0); add(4'h0, 1, 4'b0000, 0);
    add(4'b1001, 0, 4'b1000, 0); add(4'b1001, 1, 4'b0001, 0);
    add(4'b1001, 1, 4'b1000, 0); add(4'h0, 0, 4'b0000, 0);
    // withdraw leaves ptr at 1; ack while idle ignored
    add(4'b0010, 0, 4'b0010, 0); add(4'b0010, 0, 4'b0010, 0);
    add(4'h0, 0, 4'b0000, 0); add(4'hF, 0, 4'b0010, 0);
    add(4'h0, 0, 4'b0000, 0); add(4'h0, 1, 4'b0000, 0);
    add(4'b0100, 0, 4'b0100, 0); add(4'b0100, 1, 4'b0000, 0);

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].ack);
      check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].to);
    end

    // asynchronous reset mid-grant, then 1-cycle regrant
    step(4'b0010, 0);
    check("pre_rst_grant", 4'b0010, 1'b0);
    #3 rst = 1'b1;
    #1 check("rst_midgrant", '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(4'b0010, 0);
    check("post_rst_grant", 4'b0010, 1'b0);

`ifdef RR_GRANT_ARBITER_CHK_EN
    force dut.gnt = 4'b0110;
    @(posedge clk); #1;
    release dut.gnt;
    @(posedge clk); #1;
    total++;
    if (err_onehot !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got err=%b want 1", err_onehot);
    end
`endif

    // random traffic against the reference model
    rst = 1'b1; #1; rst = 1'b0;
    req = '0; ack = 1'b0;
    m_own = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      a = ($urandom_range(0, 5) == 0);
      step(r, a);
      model_edge(r, a);
      eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
      check($sformatf("rand%0d", c), eg, m_to);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
